// File: rtl/step_timer_sequencer_if.sv
// Command and timer handshake bundle between the sequencer (master) and
// the motion planner / external timer (slave).
interface step_timer_sequencer_if #(
   parameter int STEP_BITS   = 16,
   parameter int PERIOD_BITS = 8
);
   // A transfer happens on a clk_en tick where valid (cmd_valid / timer_trigger)
   // and ready (cmd_rdy / timer_rdy) are both high; the initiator holds valid and
   // its payload stable until that tick and never makes valid depend on ready.
   logic                   cmd_valid;
   logic                   cmd_rdy;
   logic [STEP_BITS-1:0]   cmd_steps;
   logic [PERIOD_BITS-1:0] cmd_period;
   logic                   cmd_dir;
   logic                   timer_trigger;
   logic [PERIOD_BITS-1:0] timer_count;
   logic                   timer_rdy;
   logic                   timer_done;

   modport master (
      input  cmd_valid, cmd_steps, cmd_period, cmd_dir, timer_rdy, timer_done,
      output cmd_rdy, timer_trigger, timer_count
   );

   modport slave (
      output cmd_valid, cmd_steps, cmd_period, cmd_dir, timer_rdy, timer_done,
      input  cmd_rdy, timer_trigger, timer_count
   );
endinterface

// File: rtl/step_timer_sequencer.sv
// Issues one step pulse per completed external-timer period for a latched
// motion command, re-arming the timer between steps.
module step_timer_sequencer #(
   parameter int STEP_BITS   = 16,
   parameter int PERIOD_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  abort,
   step_timer_sequencer_if.master bus,
   output logic                  step,
   output logic                  dir,
   output logic                  busy,
   output logic                  done,
   output logic [STEP_BITS-1:0]  steps_left,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_SETTLE = 3'd2,
      S_WAIT   = 3'd3,
      S_PULSE  = 3'd4,
      S_DONE   = 3'd5
   } state_e;

   state_e                 state_q, state_d;
   logic [STEP_BITS-1:0]   steps_left_q, steps_left_d;
   logic [PERIOD_BITS-1:0] period_q, period_d;
   logic                   dir_q, dir_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         steps_left_q <= '0;
         period_q     <= '0;
         dir_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         steps_left_q <= steps_left_d;
         period_q     <= period_d;
         dir_q        <= dir_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      steps_left_d = steps_left_q;
      period_d     = period_q;
      dir_d        = dir_q;
      if (clk_en) begin
         if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (bus.cmd_valid) begin
                     steps_left_d = bus.cmd_steps;
                     period_d     = (bus.cmd_period == '0) ? PERIOD_BITS'(1) : bus.cmd_period;
                     dir_d        = bus.cmd_dir;
                     state_d      = (bus.cmd_steps == '0) ? S_DONE : S_ARM;
                  end
               end
               S_ARM: begin
                  if (bus.timer_rdy) state_d = S_SETTLE;
               end
               // A done still asserted from the previous period is ignored here.
               S_SETTLE: state_d = S_WAIT;
               S_WAIT: begin
                  // Decrement on entry to PULSE so the count shown with the pulse is current.
                  if (bus.timer_done) begin
                     state_d      = S_PULSE;
                     steps_left_d = steps_left_q - STEP_BITS'(1);
                  end
               end
               S_PULSE: state_d = (steps_left_q == '0) ? S_DONE : S_ARM;
               S_DONE:  state_d = S_IDLE;
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   assign bus.cmd_rdy       = (state_q == S_IDLE);
   assign bus.timer_trigger = (state_q == S_ARM);
   assign bus.timer_count   = (state_q == S_ARM) ? period_q : '0;
   assign step              = (state_q == S_PULSE);
   assign done              = (state_q == S_DONE);
   assign busy              = (state_q != S_IDLE);
   assign dir               = dir_q;
   assign steps_left        = steps_left_q;
   assign state_dbg         = state_q;

endmodule

// File: tb/tb_step_timer_sequencer.sv
// Directed and randomized commands against a tick-arithmetic reference of the
// step sequencer, with a behavioural timer responding to trigger/count.
module tb_step_timer_sequencer;
   localparam int SB = 16;
   localparam int PB = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clk_en = 1'b0;
   logic          abort = 1'b0;
   logic          step, dir, busy, done;
   logic [SB-1:0] steps_left;
   logic [2:0]    state_dbg;

   step_timer_sequencer_if #(.STEP_BITS(SB), .PERIOD_BITS(PB)) bus ();

   step_timer_sequencer #(.STEP_BITS(SB), .PERIOD_BITS(PB)) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .abort      (abort),
      .bus        (bus),
      .step       (step),
      .dir        (dir),
      .busy       (busy),
      .done       (done),
      .steps_left (steps_left),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   int n_pass  = 0;
   int n_total = 0;
   int tick_no = 0;
   int cyc     = 0;

   // behavioural external timer
   bit tm_active = 1'b0;
   bit tm_stale  = 1'b0;
   bit tm_just   = 1'b0;
   int tm_cnt    = 0;
   int tm_wait   = 0;
   int tm_stall  = 0;

   // scoreboard: expected steps_left shown with each step pulse
   logic [SB-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // One clock cycle; en is the clk_en value presented at the coming edge.
   task automatic tick(input bit en);
      clk_en = en;
      if (en) begin
         if (tm_active) begin
            if (tm_cnt == 0) tm_active = 1'b0;
            else tm_cnt--;
         end
         tm_just = 1'b0;
         if (bus.timer_trigger && bus.timer_rdy) begin
            tm_active = 1'b1;
            tm_cnt    = int'(bus.timer_count);
            tm_wait   = 0;
            tm_just   = 1'b1;
         end else if (bus.timer_trigger) begin
            tm_wait++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (en) tick_no++;
      bus.timer_done = (tm_active && tm_cnt == 0) || (tm_stale && tm_just);
      bus.timer_rdy  = (tm_wait >= tm_stall);
   endtask

   // ---------------- driver: one command ----------------
   // en_pct >= 0: random clk_en density in percent; en_pct < 0: clk_en every -en_pct cycles.
   // abort_after > 0: abort on the tick that many ticks after the first step pulse.
   task automatic run_cmd(input int steps, input int period, input bit d, input int stall,
                          input int en_pct, input bit stale, input int abort_after);
      int            p_eff, a_tick, pulses, last_pulse, exp_t, cycles;
      bit            e, ab, fin;
      logic [19:0]   frz;
      p_eff    = (period == 0) ? 1 : period;
      tm_stall = stall;
      tm_stale = stale;
      tm_wait  = 0;
      bus.timer_rdy = (stall == 0);
      for (int k = 1; k <= steps; k++) exp_q.push_back(SB'(steps - k));

      chk("idle_rdy", bus.cmd_rdy, 1);
      bus.cmd_valid  = 1'b1;
      bus.cmd_steps  = SB'(steps);
      bus.cmd_period = PB'(period);
      bus.cmd_dir    = d;
      tick(1'b1);
      a_tick = tick_no;
      bus.cmd_valid  = 1'b0;
      bus.cmd_steps  = SB'($urandom);
      bus.cmd_period = PB'($urandom);
      bus.cmd_dir    = ~d;
      chk("accept_busy", busy, 1);
      chk("accept_dir", dir, d);
      chk("accept_left", steps_left, steps);
      chk("accept_rdy", bus.cmd_rdy, 0);

      if (steps == 0) begin
         chk("zero_done", done, 1);
         chk("zero_trig", bus.timer_trigger, 0);
         chk("zero_step", step, 0);
         tick(1'b1);
         chk("zero_busy_end", busy, 0);
         chk("zero_done_end", done, 0);
         chk("zero_rdy_end", bus.cmd_rdy, 1);
         return;
      end

      pulses     = 0;
      last_pulse = a_tick;
      fin        = 1'b0;
      cycles     = 0;
      while (!fin && cycles < 4000) begin
         if (en_pct < 0) e = ((cyc % (-en_pct)) == 0);
         else            e = ($urandom_range(99) < en_pct);
         ab    = (abort_after > 0) && (pulses == 1) && e && (tick_no + 1 == last_pulse + abort_after);
         abort = ab;
         frz   = {steps_left, step, done, busy, bus.timer_trigger};
         tick(e);
         abort = 1'b0;
         cycles++;
         if (!e) begin
            chk("frozen", {steps_left, step, done, busy, bus.timer_trigger}, frz);
         end else if (ab) begin
            chk("abort_rdy", bus.cmd_rdy, 1);
            chk("abort_busy", busy, 0);
            chk("abort_step", step, 0);
            chk("abort_done", done, 0);
            chk("abort_trig", bus.timer_trigger, 0);
            chk("abort_left", steps_left, SB'(steps - 1));
            repeat (p_eff + 4) begin
               tick(1'b1);
               chk("abort_quiet", {step, done, busy, bus.timer_trigger}, 0);
            end
            exp_q.delete();
            fin = 1'b1;
         end else begin
            if (bus.timer_trigger) chk("trig_count", bus.timer_count, p_eff);
            if (step) begin
               pulses++;
               exp_t = a_tick + p_eff + 2 + stall + (pulses - 1) * (p_eff + 3 + stall);
               chk("step_tick", tick_no, exp_t);
               if (exp_q.size() > 0) chk("step_left", steps_left, exp_q.pop_front());
               else                  chk("step_extra", pulses, steps);
               chk("step_dir", dir, d);
               last_pulse = tick_no;
            end
            if (done) begin
               chk("done_tick", tick_no, last_pulse + 1);
               chk("done_pulses", pulses, steps);
               chk("done_left", steps_left, 0);
               tick(1'b1);
               chk("end_rdy", bus.cmd_rdy, 1);
               chk("end_busy", busy, 0);
               chk("end_done", done, 0);
               chk("end_dir", dir, d);
               fin = 1'b1;
            end
         end
      end
      if (!fin) chk("timeout", cycles, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int a;
      int n;
      bus.cmd_valid  = 1'b0;
      bus.cmd_steps  = '0;
      bus.cmd_period = '0;
      bus.cmd_dir    = 1'b0;
      bus.timer_rdy  = 1'b1;
      bus.timer_done = 1'b0;
      @(negedge clk);
      tick(1'b0);
      tick(1'b1);
      reset = 1'b0;

      chk("rst_cmd_rdy", bus.cmd_rdy, 1);
      chk("rst_trigger", bus.timer_trigger, 0);
      chk("rst_count", bus.timer_count, 0);
      chk("rst_step", step, 0);
      chk("rst_dir", dir, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_steps_left", steps_left, 0);

      run_cmd(3, 4, 1'b1, 0, 100, 1'b0, 0);
      run_cmd(0, 7, 1'b0, 0, 100, 1'b0, 0);
      run_cmd(2, 3, 1'b1, 5, 100, 1'b0, 0);
      run_cmd(5, 8, 1'b0, 0, 100, 1'b0, 4);

      abort = 1'b1;
      tick(1'b1);
      abort = 1'b0;
      chk("idle_abort_rdy", bus.cmd_rdy, 1);
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_left", steps_left, 4);

      run_cmd(2, 4, 1'b1, 0, -3, 1'b0, 0);
      run_cmd(3, 2, 1'b0, 1, 100, 1'b1, 0);

      // reset while a step pulse is showing; period 0 runs as period 1
      tm_stall = 0;
      tm_stale = 1'b0;
      bus.cmd_valid  = 1'b1;
      bus.cmd_steps  = SB'(3);
      bus.cmd_period = '0;
      bus.cmd_dir    = 1'b1;
      tick(1'b1);
      a = tick_no;
      bus.cmd_valid = 1'b0;
      n = 0;
      while (!step && n < 50) begin
         tick(1'b1);
         n++;
      end
      chk("rp_reached_pulse", step, 1);
      chk("rp_period0_tick", tick_no - a, 3);
      reset = 1'b1;
      tick(1'b0);
      chk("rp_cmd_rdy", bus.cmd_rdy, 1);
      chk("rp_trigger", bus.timer_trigger, 0);
      chk("rp_count", bus.timer_count, 0);
      chk("rp_step", step, 0);
      chk("rp_dir", dir, 0);
      chk("rp_busy", busy, 0);
      chk("rp_done", done, 0);
      chk("rp_steps_left", steps_left, 0);
      reset = 1'b0;
      tm_active = 1'b0;
      tm_wait   = 0;
      tm_just   = 1'b0;
      bus.timer_done = 1'b0;
      bus.timer_rdy  = 1'b1;
      tick(1'b1);

      repeat (20) begin
         run_cmd($urandom_range(4), $urandom_range(6), 1'($urandom), $urandom_range(3),
                 $urandom_range(100, 30), 1'($urandom), 0);
         repeat ($urandom_range(3)) tick(1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
